// File: rtl/cfi_pkg.sv
// Types and constants for the commit-stage CFI log stream and shadow stack checker.
package cfi_pkg;
    typedef enum logic [2:0] {
        CFI_NONE   = 3'd0,
        CFI_CALL   = 3'd1,
        CFI_RET    = 3'd2,
        CFI_CORET  = 3'd3,
        CFI_JUMP   = 3'd4,
        CFI_BRANCH = 3'd5
    } cfi_kind_e;

    typedef struct packed {
        logic [riscv::VLEN-1:0] pc;
        logic [riscv::VLEN-1:0] target;
        cfi_kind_e              kind;
        logic                   rvc;
    } cfi_commit_log_t;

    typedef struct packed {
        logic [riscv::XLEN-1:0] cause;
        logic [riscv::XLEN-1:0] tval;
        logic                   valid;
    } exception_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FAULT = 1'b1
    } chk_state_e;

    localparam logic [riscv::XLEN-1:0] CFI_CAUSE_RET_MISMATCH  = riscv::XLEN'(24);
    localparam logic [riscv::XLEN-1:0] CFI_CAUSE_RET_UNDERFLOW = riscv::XLEN'(25);
endpackage

// File: rtl/riscv_pkg.sv
// Core-wide width constants shared by the CFI log producer and consumer.
package riscv;
    localparam int unsigned VLEN = 64;
    localparam int unsigned XLEN = 64;
endpackage

// File: rtl/cfi_ret_stack.sv
// Circular return-address LIFO: push on full overwrites the oldest entry; clear beats push/pop.
module cfi_ret_stack #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_n, wr_addr;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             wr_en;

    always_comb begin
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = ptr_q + PTR_W'(1);
        if (clear_i) begin
            ptr_n = '0;
            cnt_n = '0;
        end else if (push_i && pop_i) begin
            // Pop then push nets out to replacing the top entry in place.
            wr_en   = 1'b1;
            wr_addr = ptr_q;
        end else if (push_i) begin
            wr_en = 1'b1;
            ptr_n = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_n = cnt_q + CNT_W'(1);
            end
        end else if (pop_i && (cnt_q != '0)) begin
            ptr_n = ptr_q - PTR_W'(1);
            cnt_n = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_n;
            cnt_q <= cnt_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= data_i;
        end
    end

    assign top_o   = mem[ptr_q];
    assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/cfi_shadow_stack_checker.sv
// Checks committed returns against a hardware shadow stack and reports a sticky fault until acknowledged.
module cfi_shadow_stack_checker import cfi_pkg::*; #(
    parameter int unsigned DEPTH = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic            clear_i,
    input  logic            log_valid_i,
    output logic            log_ready_o,
    input  cfi_commit_log_t log_i,
    output exception_t      fault_o,
    input  logic            fault_ack_i
);
    chk_state_e             state_q, state_n;
    logic [riscv::XLEN-1:0] cause_q, cause_n;
    logic [riscv::XLEN-1:0] tval_q, tval_n;
    logic [riscv::VLEN-1:0] top, ret_addr;
    logic empty, accept, check, underflow, mismatch, fault, push, pop;

    cfi_ret_stack #(
        .DEPTH (DEPTH),
        .WIDTH (riscv::VLEN)
    ) u_stack (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (ret_addr),
        .top_o   (top),
        .empty_o (empty)
    );

    assign ret_addr = log_i.pc + (log_i.rvc ? riscv::VLEN'(2) : riscv::VLEN'(4));

    always_comb begin
        accept    = log_valid_i && (state_q == IDLE);
        check     = accept && enable_i && ((log_i.kind == CFI_RET) || (log_i.kind == CFI_CORET));
        underflow = check && empty;
        mismatch  = check && !empty && (log_i.target != top);
        fault     = underflow || mismatch;
        pop       = check && !fault;
        // A CORET only pushes once its return half has checked clean.
        push      = accept && enable_i && !fault &&
                    ((log_i.kind == CFI_CALL) || (log_i.kind == CFI_CORET));
    end

    always_comb begin
        state_n = state_q;
        cause_n = cause_q;
        tval_n  = tval_q;
        case (state_q)
            IDLE: begin
                if (fault) begin
                    state_n = FAULT;
                    cause_n = underflow ? CFI_CAUSE_RET_UNDERFLOW : CFI_CAUSE_RET_MISMATCH;
                    tval_n  = riscv::XLEN'(log_i.target);
                end
            end
            FAULT: begin
                if (fault_ack_i) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cause_q <= '0;
            tval_q  <= '0;
        end else begin
            state_q <= state_n;
            cause_q <= cause_n;
            tval_q  <= tval_n;
        end
    end

    assign fault_o.valid = (state_q == FAULT);
    assign fault_o.cause = cause_q;
    assign fault_o.tval  = tval_q;
    assign log_ready_o   = (state_q != FAULT);
endmodule
